uram_bist_ctrl: RTL and testbench

- Sequencer that runs a write-then-readback self-test on one simple-dual-port URAM (port A write, port B read).
- On start, it fills every address with a seed-derived pattern, then reads every address back through the RAM's fixed read latency and compares each word.
- It reports done, pass/fail, error count and first failing address.
- Sits between the test/host logic and the URAM primitive, replacing a free-running address/data stimulus generator.

---
 rtl/uram_bist_pkg.sv | 26 ++
 rtl/uram_bist_cmp.sv | 65 ++++++
 rtl/uram_bist_ctrl.sv | 146 ++++++++++++++
 tb/tb_uram_bist_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uram_bist_pkg.sv
// Shared types and helpers for the URAM write/readback self-test sequencer.
package uram_bist_pkg;

    localparam int DEF_DATA_DEPTH = 4096;
    localparam int AW             = $clog2(DEF_DATA_DEPTH);

    // Pattern arithmetic is done at this width and truncated by the caller.
    // The low bits of a sum never depend on the discarded high bits, so the
    // result is the required modulo-2^DATA_WIDTH value for any DATA_WIDTH up
    // to this width.
    localparam int PAT_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] seed,
                                             input logic [PAT_W-1:0] addr);
        return seed + addr;
    endfunction

endpackage

// File: rtl/uram_bist_cmp.sv
// Read-tracking delay line, readback comparator and saturating error counter.
module uram_bist_cmp
    import uram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_W     = AW,
    parameter int RD_LAT     = 2,
    parameter int ERR_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0] seed_q,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic [ERR_W-1:0]      err_cnt,
    output logic [ADDR_W-1:0]     first_err_addr
);

    logic [RD_LAT-1:0] trk_vld;
    logic [ADDR_W-1:0] trk_addr [RD_LAT];
    logic [DATA_WIDTH-1:0] exp_data;
    logic mismatch;

    assign exp_data = DATA_WIDTH'(pat(PAT_W'(seed_q), PAT_W'(trk_addr[RD_LAT-1])));
    // Untracked cycles are masked, so garbage or X on doutb is never counted.
    assign mismatch = trk_vld[RD_LAT-1] && (doutb != exp_data);

    // Follow each issued read until its data appears on doutb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                trk_addr[i] <= '0;
            end
        end else begin
            trk_vld[0]  <= rd_en;
            trk_addr[0] <= rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                trk_vld[i]  <= trk_vld[i-1];
                trk_addr[i] <= trk_addr[i-1];
            end
        end
    end

    // Count mismatches (saturating) and latch the address of the first one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (clr) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (mismatch) begin
            if (err_cnt == '0) begin
                first_err_addr <= trk_addr[RD_LAT-1];
            end
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: rtl/uram_bist_ctrl.sv
// Write-then-readback self-test sequencer for a simple-dual-port URAM.
//
// state | meaning
// IDLE  | waiting for start
// WRITE | one pattern word per clock on port A
// READ  | one read per clock on port B
// DRAIN | let the last reads reach the comparator
// DONE  | one-cycle done pulse, pass valid
module uram_bist_ctrl
    import uram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 72,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int RD_LAT     = 2,
    parameter int ERR_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         seed,
    output logic                          wea,
    output logic [$clog2(DATA_DEPTH)-1:0] addra,
    output logic [DATA_WIDTH-1:0]         dina,
    output logic                          enb,
    output logic [$clog2(DATA_DEPTH)-1:0] addrb,
    input  logic [DATA_WIDTH-1:0]         doutb,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [ERR_W-1:0]              err_cnt,
    output logic [$clog2(DATA_DEPTH)-1:0] first_err_addr
);

    localparam int ADDR_W = $clog2(DATA_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_DEPTH - 1);
    // DRAIN lasts RD_LAT+1 cycles: RD_LAT for the last read to compare,
    // one more for err_cnt to settle before pass is sampled.
    localparam logic [2:0] DRAIN_LOAD = 3'(RD_LAT);

    state_t                state;
    logic [ADDR_W-1:0]     cnt;
    logic [ADDR_W-1:0]     cnt_nxt;
    logic [2:0]            drain_cnt;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  clr;

    assign cnt_nxt = cnt + ADDR_W'(1);
    assign clr     = (state == IDLE) && start;

    function automatic logic [DATA_WIDTH-1:0] pat_w(input logic [DATA_WIDTH-1:0] s,
                                                    input logic [ADDR_W-1:0]     a);
        return DATA_WIDTH'(pat(PAT_W'(s), PAT_W'(a)));
    endfunction

    // Sequencer: write sweep, read sweep, pipeline drain, result report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            seed_q    <= '0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            enb       <= 1'b0;
            addrb     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= WRITE;
                        seed_q <= seed;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        pass   <= 1'b0;
                        wea    <= 1'b1;
                        addra  <= '0;
                        dina   <= seed;
                    end
                end
                WRITE: begin
                    if (cnt == LAST_ADDR) begin
                        state <= READ;
                        cnt   <= '0;
                        wea   <= 1'b0;
                        enb   <= 1'b1;
                        addrb <= '0;
                    end else begin
                        cnt   <= cnt_nxt;
                        addra <= cnt_nxt;
                        dina  <= pat_w(seed_q, cnt_nxt);
                    end
                end
                READ: begin
                    if (cnt == LAST_ADDR) begin
                        state     <= DRAIN;
                        cnt       <= '0;
                        enb       <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                    end else begin
                        cnt   <= cnt_nxt;
                        addrb <= cnt_nxt;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0);
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    uram_bist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT),
        .ERR_W      (ERR_W)
    ) u_cmp (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .rd_en          (enb),
        .rd_addr        (addrb),
        .seed_q         (seed_q),
        .doutb          (doutb),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_uram_bist_ctrl.sv
// Directed bench for uram_bist_ctrl with behavioural URAM models.
module tb_uram_bist_ctrl;

    localparam int DW    = 72;
    localparam int DEPTH = 16;
    localparam int AWT   = 4;
    localparam int LAT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic           start0 = 1'b0;
    logic [DW-1:0]  seed0  = '0;
    logic           wea0, enb0, busy0, done0, pass0;
    logic [AWT-1:0] addra0, addrb0, first0;
    logic [DW-1:0]  dina0, doutb0;
    logic [15:0]    err0;

    logic           start1 = 1'b0;
    logic [DW-1:0]  seed1  = 72'h12_3456_789A_BCDE_F012;
    logic           wea1, enb1, busy1, done1, pass1;
    logic [AWT-1:0] addra1, addrb1, first1;
    logic [DW-1:0]  dina1, doutb1;
    logic [2:0]     err1;

    logic [DEPTH-1:0] corrupt0 = '0;
    logic [DW-1:0]    mem0 [DEPTH];
    logic [DW-1:0]    pipe0 [LAT];
    logic [DW-1:0]    mem1 [DEPTH];
    logic [DW-1:0]    pipe1 [LAT];
    logic [DW-1:0]    wr_data [DEPTH];
    int wr_cnt = 0;
    int rd_cnt = 0;

    uram_bist_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .RD_LAT(LAT), .ERR_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed0),
        .wea(wea0), .addra(addra0), .dina(dina0), .enb(enb0), .addrb(addrb0), .doutb(doutb0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .first_err_addr(first0));

    uram_bist_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .RD_LAT(LAT), .ERR_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed1),
        .wea(wea1), .addra(addra1), .dina(dina1), .enb(enb1), .addrb(addrb1), .doutb(doutb1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(first1));

    // RAM model for dut0: selected addresses read back with bit 0 flipped.
    always @(posedge clk) begin
        if (wea0) mem0[addra0] <= dina0;
        if (enb0) pipe0[0] <= mem0[addrb0] ^ DW'(corrupt0[addrb0]);
        for (int i = 1; i < LAT; i++) pipe0[i] <= pipe0[i-1];
    end
    assign doutb0 = pipe0[LAT-1];

    // RAM model for dut1: every read comes back corrupted.
    always @(posedge clk) begin
        if (wea1) mem1[addra1] <= dina1;
        if (enb1) pipe1[0] <= mem1[addrb1] ^ DW'(1);
        for (int i = 1; i < LAT; i++) pipe1[i] <= pipe1[i-1];
    end
    assign doutb1 = pipe1[LAT-1];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Capture write data per address, count accesses, and police port overlap.
    always @(negedge clk) begin
        if (wea0) begin
            wr_data[addra0] <= dina0;
            wr_cnt <= wr_cnt + 1;
        end
        if (enb0) rd_cnt <= rd_cnt + 1;
        if (rst_n) begin
            check_val("no_overlap0", DW'(wea0 & enb0), '0);
            check_val("no_overlap1", DW'(wea1 & enb1), '0);
        end
    end

    task automatic wait_done(input int sel, input int from, output int cyc);
        cyc = from;
        while (!(sel == 1 ? done1 : done0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run0(input logic [DW-1:0] s, output int cyc);
        seed0  = s;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 1, cyc);
    endtask

    initial begin
        int cyc, bw, br;
        repeat (3) @(negedge clk);
        check_val("rst_wea", DW'(wea0), '0);
        check_val("rst_enb", DW'(enb0), '0);
        check_val("rst_busy", DW'(busy0), '0);
        check_val("rst_pass", DW'(pass0), '0);
        check_val("rst_err", DW'(err0), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // seed 0: data equals address
        bw = wr_cnt;
        br = rd_cnt;
        seed0  = '0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check_val("t1_busy", DW'(busy0), 72'd1);
        check_val("t1_first_wr", DW'(wea0), 72'd1);
        wait_done(0, 1, cyc);
        check_val("t1_cycles", DW'(cyc), 72'd36);
        check_val("t1_pass", DW'(pass0), 72'd1);
        check_val("t1_err", DW'(err0), 72'd0);
        check_val("t1_busy_done", DW'(busy0), 72'd0);
        check_val("t1_nwr", DW'(wr_cnt - bw), 72'd16);
        check_val("t1_nrd", DW'(rd_cnt - br), 72'd16);
        check_val("t1_wd0", wr_data[0], 72'd0);
        check_val("t1_wd7", wr_data[7], 72'd7);
        check_val("t1_wd15", wr_data[15], 72'd15);
        @(negedge clk);
        check_val("t1_done_1cyc", DW'(done0), 72'd0);

        // carry/wrap of the pattern adder
        run0(72'hFF_FFFF_FFFF_FFFF_FFF0, cyc);
        check_val("t2_cycles", DW'(cyc), 72'd36);
        check_val("t2_wd0", wr_data[0], 72'hFF_FFFF_FFFF_FFFF_FFF0);
        check_val("t2_wd15", wr_data[15], 72'hFF_FFFF_FFFF_FFFF_FFFF);
        check_val("t2_pass", DW'(pass0), 72'd1);
        check_val("t2_err", DW'(err0), 72'd0);
        @(negedge clk);

        // corrupted reads at 5 and 9
        corrupt0 = 16'h0220;
        run0(72'h01_2345_6789_ABCD_EF00, cyc);
        check_val("t3_err", DW'(err0), 72'd2);
        check_val("t3_first", DW'(first0), 72'd5);
        check_val("t3_pass", DW'(pass0), 72'd0);
        repeat (5) @(negedge clk);
        check_val("t3_pass_hold", DW'(pass0), 72'd0);
        check_val("t3_err_hold", DW'(err0), 72'd2);
        corrupt0 = '0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check_val("t3_err_clr", DW'(err0), 72'd0);
        check_val("t3_first_clr", DW'(first0), 72'd0);
        wait_done(0, 1, cyc);
        check_val("t3_pass_new", DW'(pass0), 72'd1);
        @(negedge clk);

        // start during WRITE and in the DONE cycle is ignored
        seed0  = 72'h00_0000_0000_0000_0100;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        while (!(wea0 && addra0 == 4'd7) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_val("t4_at7", DW'(cyc), 72'd8);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc++;
        check_val("t4_no_restart", DW'(addra0), 72'd8);
        wait_done(0, cyc, cyc);
        check_val("t4_cycles", DW'(cyc), 72'd36);
        check_val("t4_pass", DW'(pass0), 72'd1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check_val("t4_ign_done", DW'(busy0), 72'd0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check_val("t4_restart", DW'(busy0), 72'd1);
        wait_done(0, 1, cyc);
        check_val("t4_cycles2", DW'(cyc), 72'd36);
        @(negedge clk);

        // saturation with a 3-bit error counter
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 1, cyc);
        check_val("t5_cycles", DW'(cyc), 72'd36);
        check_val("t5_err_sat", DW'(err1), 72'd7);
        check_val("t5_first", DW'(first1), 72'd0);
        check_val("t5_pass", DW'(pass1), 72'd0);
        @(negedge clk);

        // reset mid-READ, then a clean run
        corrupt0 = 16'h0006;
        seed0  = 72'h00_0000_0000_0000_0055;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        while (!(enb0 && addrb0 == 4'd4) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_val("t6_at_rd4", DW'(cyc), 72'd21);
        check_val("t6_pre_err", DW'(err0), 72'd1);
        check_val("t6_pre_first", DW'(first0), 72'd1);
        rst_n = 1'b0;
        #1;
        check_val("t6_enb", DW'(enb0), 72'd0);
        check_val("t6_wea", DW'(wea0), 72'd0);
        check_val("t6_addrb", DW'(addrb0), 72'd0);
        check_val("t6_addra", DW'(addra0), 72'd0);
        check_val("t6_dina", dina0, 72'd0);
        check_val("t6_busy", DW'(busy0), 72'd0);
        check_val("t6_pass", DW'(pass0), 72'd0);
        check_val("t6_err", DW'(err0), 72'd0);
        check_val("t6_first", DW'(first0), 72'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("t6_idle_busy", DW'(busy0), 72'd0);
            check_val("t6_no_done", DW'(done0), 72'd0);
        end
        corrupt0 = '0;
        run0(72'h00_0000_0000_0000_0077, cyc);
        check_val("t6_cycles", DW'(cyc), 72'd36);
        check_val("t6_clean_pass", DW'(pass0), 72'd1);
        check_val("t6_clean_err", DW'(err0), 72'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
